// File: rtl/prio_encoder_irq_if.sv
// rtl/prio_encoder_irq_if.sv - request/grant bundle between requesters and the priority encoder
interface prio_encoder_irq_if #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         ack;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_multi;
    logic [N-1:0] pending;

    modport master (
        output req, mask, ack,
        input  out_valid, out_idx, out_multi, pending
    );

    modport slave (
        input  req, mask, ack,
        output out_valid, out_idx, out_multi, pending
    );
endinterface

// File: rtl/prio_encoder_irq.sv
// rtl/prio_encoder_irq.sv - latched N-line priority encoder with valid/ack grant hold
module prio_encoder_irq #(
    parameter int N         = 8,
    parameter int EDGE_MODE = 0,
    parameter int LSB_HIGH  = 1
) (
    input  logic               clk,
    input  logic               rst,
    prio_encoder_irq_if.slave  bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {ST_IDLE, ST_PRESENT} state_t;

    state_t       r_state;
    logic [N-1:0] r_pending;
    logic [N-1:0] r_req_d;
    logic         r_valid;
    logic [W-1:0] r_idx;
    logic         r_multi;

    logic [N-1:0] w_set;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_elig;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_multi;

    always_comb begin
        w_elig  = r_pending & ~bus.mask;
        w_set   = (EDGE_MODE != 0) ? (bus.req & ~r_req_d) : bus.req;
        w_clr   = '0;
        w_idx   = '0;
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.ack && r_valid && (r_idx == W'(i)))
                w_clr[i] = 1'b1;
        end
        // Scan from lowest to highest priority so the last hit is the winner.
        if (LSB_HIGH != 0) begin
            for (int i = N - 1; i >= 0; i--)
                if (w_elig[i]) w_idx = W'(i);
        end else begin
            for (int i = 0; i < N; i++)
                if (w_elig[i]) w_idx = W'(i);
        end
        for (int i = 0; i < N; i++) begin
            if (w_elig[i]) begin
                if (w_any) w_multi = 1'b1;
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_req_d   <= '0;
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_multi   <= 1'b0;
        end else begin
            r_req_d   <= bus.req;
            r_pending <= w_set | (r_pending & ~w_clr);
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_idx;
                        r_multi <= w_multi;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.ack) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.out_multi = r_multi;
    assign bus.pending   = r_pending;
endmodule
